// File: rtl/packet_fifo_v2_pkg.sv
// Shared sizing helpers and pointer wrap arithmetic for packet_fifo_v2.
package packet_fifo_v2_pkg;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Modulo-depth increment; depth need not be a power of two.
  function automatic int wrap_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/packet_fifo_v2_ptr_wrap.sv
// Pointer register: advances by one on en, wraps DEPTH-1 -> 0.
// Updates on the clock edge after en; no backpressure of its own.
module packet_fifo_v2_ptr_wrap
  import packet_fifo_v2_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= PTR_W'(wrap_inc(int'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/packet_fifo_v2.sv
// Packet FIFO with arbitrary depth, registered read port (1-cycle latency) and level flags.
// Write refused only when full with no read; optional sticky error flags under PACKET_FIFO_ERR_FLAGS_EN.
module packet_fifo_v2
  import packet_fifo_v2_pkg::*;
#(
  parameter int FIFO_DEPTH         = 32,
  parameter int DATA_LINE_WIDTH    = 40,
  parameter int CONTROL_LINE_WIDTH = 0,
  parameter int ALMOST_FULL_LVL    = FIFO_DEPTH - 4,
  parameter int ALMOST_EMPTY_LVL   = 4,
  localparam int PW = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH,
  localparam int CW = cnt_w(FIFO_DEPTH),
  localparam int AW = ptr_w(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_write_packet_en,
  input  logic [PW-1:0] i_write_packet,
  output logic          o_write_ready,
  input  logic          i_read_packet_en,
  output logic [PW-1:0] o_read_packet,
  output logic          o_read_valid,
  output logic          o_empty_flag,
  output logic          o_full_flag,
  output logic          o_almost_full,
  output logic          o_almost_empty,
`ifdef PACKET_FIFO_ERR_FLAGS_EN
  input  logic          i_err_clr,
  output logic          o_overflow,
  output logic          o_underflow,
`endif
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          rd_acc;
  logic          wr_acc;

  assign o_empty_flag   = (count == '0);
  assign o_full_flag    = (count == CW'(FIFO_DEPTH));
  assign o_almost_full  = (int'(count) >= ALMOST_FULL_LVL);
  assign o_almost_empty = (int'(count) <= ALMOST_EMPTY_LVL);
  assign o_count        = count;

  // A read in the same cycle frees a slot, so a full FIFO can still take a write.
  assign o_write_ready = ~o_full_flag | i_read_packet_en;
  assign rd_acc        = i_read_packet_en & ~o_empty_flag;
  assign wr_acc        = i_write_packet_en & (~o_full_flag | rd_acc);

  packet_fifo_v2_ptr_wrap #(.DEPTH(FIFO_DEPTH), .PTR_W(AW)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (rd_acc),
    .ptr (head)
  );

  packet_fifo_v2_ptr_wrap #(.DEPTH(FIFO_DEPTH), .PTR_W(AW)) u_tail (
    .clk (clk),
    .rst (rst),
    .en  (wr_acc),
    .ptr (tail)
  );

  // At full with read+write, head == tail: the read samples the old entry before it is overwritten.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[tail] <= i_write_packet;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_read_valid  <= 1'b0;
      o_read_packet <= '0;
    end else begin
      o_read_valid  <= rd_acc;
      o_read_packet <= rd_acc ? mem[head] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PACKET_FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = i_write_packet_en & ~o_write_ready;
  assign unf_set = i_read_packet_en & o_empty_flag;

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= ovf_set | (o_overflow & ~i_err_clr);
      o_underflow <= unf_set | (o_underflow & ~i_err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_packet_fifo_v2.sv
// Scoreboard bench for packet_fifo_v2: depth-32 instance for main tests, depth-5 instance for wrap test.
module tb_packet_fifo_v2;

  localparam int PW = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic          a_we = 1'b0, a_re = 1'b0;
  logic [PW-1:0] a_wd = '0;
  logic [PW-1:0] a_rd;
  logic          a_rv, a_empty, a_full, a_af, a_ae, a_wr_rdy;
  logic [5:0]    a_cnt;

  logic          b_we = 1'b0, b_re = 1'b0;
  logic [PW-1:0] b_wd = '0;
  logic [PW-1:0] b_rd;
  logic          b_rv, b_empty, b_full, b_af, b_ae, b_wr_rdy;
  logic [2:0]    b_cnt;

`ifdef PACKET_FIFO_ERR_FLAGS_EN
  logic a_clr = 1'b0, a_ovf, a_unf;
  logic b_clr = 1'b0, b_ovf, b_unf;
`endif

  packet_fifo_v2 dut_a (
    .clk(clk), .rst(rst),
    .i_write_packet_en(a_we), .i_write_packet(a_wd), .o_write_ready(a_wr_rdy),
    .i_read_packet_en(a_re), .o_read_packet(a_rd), .o_read_valid(a_rv),
    .o_empty_flag(a_empty), .o_full_flag(a_full),
    .o_almost_full(a_af), .o_almost_empty(a_ae),
`ifdef PACKET_FIFO_ERR_FLAGS_EN
    .i_err_clr(a_clr), .o_overflow(a_ovf), .o_underflow(a_unf),
`endif
    .o_count(a_cnt)
  );

  packet_fifo_v2 #(.FIFO_DEPTH(5)) dut_b (
    .clk(clk), .rst(rst),
    .i_write_packet_en(b_we), .i_write_packet(b_wd), .o_write_ready(b_wr_rdy),
    .i_read_packet_en(b_re), .o_read_packet(b_rd), .o_read_valid(b_rv),
    .o_empty_flag(b_empty), .o_full_flag(b_full),
    .o_almost_full(b_af), .o_almost_empty(b_ae),
`ifdef PACKET_FIFO_ERR_FLAGS_EN
    .i_err_clr(b_clr), .o_overflow(b_ovf), .o_underflow(b_unf),
`endif
    .o_count(b_cnt)
  );

  logic [PW-1:0] mdl_a[$], exp_a[$];
  logic [PW-1:0] mdl_b[$], exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic step_a(input logic we, input logic [PW-1:0] wd, input logic re);
    bit rok, wok;
    a_we = we; a_wd = wd; a_re = re;
    rok = re && (mdl_a.size() > 0);
    wok = we && (mdl_a.size() < 32 || rok);
    if (rok) exp_a.push_back(mdl_a.pop_front());
    if (wok) mdl_a.push_back(wd);
    @(posedge clk); #1;
    a_we = 1'b0; a_re = 1'b0; a_wd = '0;
  endtask

  task automatic step_b(input logic we, input logic [PW-1:0] wd, input logic re);
    bit rok, wok;
    b_we = we; b_wd = wd; b_re = re;
    rok = re && (mdl_b.size() > 0);
    wok = we && (mdl_b.size() < 5 || rok);
    if (rok) exp_b.push_back(mdl_b.pop_front());
    if (wok) mdl_b.push_back(wd);
    @(posedge clk); #1;
    b_we = 1'b0; b_re = 1'b0; b_wd = '0;
  endtask

  // Monitors: every valid read must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_rv) begin
        if (exp_a.size() == 0) check("a_unexpected_valid", 64'(a_rv), 64'(0));
        else check("a_read_data", 64'(a_rd), 64'(exp_a.pop_front()));
      end else begin
        check("a_idle_data", 64'(a_rd), 64'(0));
      end
      if (b_rv) begin
        if (exp_b.size() == 0) check("b_unexpected_valid", 64'(b_rv), 64'(0));
        else check("b_read_data", 64'(b_rd), 64'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_empty", 64'(a_empty), 64'(1));
    check("rst_full", 64'(a_full), 64'(0));
    check("rst_count", 64'(a_cnt), 64'(0));
    check("rst_valid", 64'(a_rv), 64'(0));
    check("rst_data", 64'(a_rd), 64'(0));
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // T1: fill with 0..31
    for (int i = 0; i < 32; i++) begin
      step_a(1'b1, PW'(i), 1'b0);
      check("t1_count", 64'(a_cnt), 64'(i + 1));
      check("t1_almost_full", 64'(a_af), 64'((i + 1) >= 28));
      check("t1_almost_empty", 64'(a_ae), 64'((i + 1) <= 4));
    end
    check("t1_full", 64'(a_full), 64'(1));
    check("t1_write_ready", 64'(a_wr_rdy), 64'(0));
    step_a(1'b1, PW'(99), 1'b0);
    check("t1_drop_count", 64'(a_cnt), 64'(32));
`ifdef PACKET_FIFO_ERR_FLAGS_EN
    check("t1_overflow", 64'(a_ovf), 64'(1));
`endif

    // T2: full, simultaneous write 0xAA and read
    a_re = 1'b1; #1;
    check("t2_write_ready_rd", 64'(a_wr_rdy), 64'(1));
    step_a(1'b1, PW'('hAA), 1'b1);
    check("t2_count", 64'(a_cnt), 64'(32));
    check("t2_valid", 64'(a_rv), 64'(1));
    for (int i = 0; i < 32; i++) step_a(1'b0, '0, 1'b1);
    check("t2_drained_empty", 64'(a_empty), 64'(1));
    check("t2_drained_count", 64'(a_cnt), 64'(0));

    // T3: empty, simultaneous read and write 0x55
    step_a(1'b1, PW'('h55), 1'b1);
    check("t3_no_valid", 64'(a_rv), 64'(0));
    check("t3_count", 64'(a_cnt), 64'(1));
    step_a(1'b0, '0, 1'b1);
    check("t3_valid", 64'(a_rv), 64'(1));
    check("t3_empty", 64'(a_empty), 64'(1));

    // T4: depth 5, fill then 12 full-level read+write cycles (3 wraps)
    for (int i = 0; i < 5; i++) step_b(1'b1, PW'('h100 + i), 1'b0);
    check("t4_full", 64'(b_full), 64'(1));
    for (int i = 5; i < 17; i++) begin
      step_b(1'b1, PW'('h100 + i), 1'b1);
      check("t4_count", 64'(b_cnt), 64'(5));
    end
    for (int i = 0; i < 5; i++) step_b(1'b0, '0, 1'b1);
    check("t4_empty", 64'(b_empty), 64'(1));

    // T5: 10 entries, then async reset while a read result is valid
    for (int i = 0; i < 10; i++) step_a(1'b1, PW'('h200 + i), 1'b0);
    step_a(1'b0, '0, 1'b1);
    #6;
    check("t5_pre_valid", 64'(a_rv), 64'(1));
    check("t5_pre_count", 64'(a_cnt), 64'(9));
    rst = 1'b1;
    #1;
    check("t5_empty", 64'(a_empty), 64'(1));
    check("t5_count", 64'(a_cnt), 64'(0));
    check("t5_valid", 64'(a_rv), 64'(0));
    mdl_a.delete();
    exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step_a(1'b1, PW'('h77), 1'b0);
    step_a(1'b0, '0, 1'b1);
    check("t5_new_valid", 64'(a_rv), 64'(1));

`ifdef PACKET_FIFO_ERR_FLAGS_EN
    // T6: sticky underflow and clear priority
    check("t6_after_rst", 64'(a_unf), 64'(0));
    step_a(1'b0, '0, 1'b1);
    check("t6_set", 64'(a_unf), 64'(1));
    step_a(1'b0, '0, 1'b0);
    check("t6_sticky", 64'(a_unf), 64'(1));
    a_clr = 1'b1;
    step_a(1'b0, '0, 1'b0);
    a_clr = 1'b0;
    check("t6_cleared", 64'(a_unf), 64'(0));
    a_clr = 1'b1;
    step_a(1'b0, '0, 1'b1);
    a_clr = 1'b0;
    check("t6_set_wins", 64'(a_unf), 64'(1));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("a_pending_reads", 64'(exp_a.size()), 64'(0));
    check("b_pending_reads", 64'(exp_b.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
